// File: rtl/step_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : step_controller_if
// Description : Pushbutton inputs and strobe/status outputs of step_controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface step_controller_if;
    logic [2:0]  key_n;
    logic        step_pulse;
    logic        latch_pulse;
    logic        running;
    logic [31:0] step_count;

    // Board / bench side: drives the keys, observes the strobes
    modport master (
        output key_n,
        input  step_pulse,
        input  latch_pulse,
        input  running,
        input  step_count
    );

    // Controller side
    modport slave (
        input  key_n,
        output step_pulse,
        output latch_pulse,
        output running,
        output step_count
    );
endinterface
`default_nettype wire

// File: rtl/step_controller.sv
`default_nettype none
// ============================================================================
// Module      : step_controller
// Description : Debounces three active-low pushbuttons into single-cycle step
//               and latch strobes, with an auto-run mode and a step counter.
// Revision    : 1.0 - initial release
// ============================================================================
module step_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIVIDE      = 5000000
) (
    input  wire logic         clock,
    input  wire logic         reset,
    step_controller_if.slave  bus
);

    localparam int c_DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int c_RUN_W = $clog2(RUN_DIVIDE);

    localparam logic [c_DB_W-1:0]  c_DB_TERM  = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0]  c_DB_ONE   = c_DB_W'(1);
    localparam logic [c_RUN_W-1:0] c_RUN_TERM = c_RUN_W'(RUN_DIVIDE - 1);
    localparam logic [c_RUN_W-1:0] c_RUN_ONE  = c_RUN_W'(1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [2:0]         r_s1;
    logic [2:0]         r_s2;
    logic [2:0]         w_press;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_RUN_W-1:0] r_rate;
    logic [c_RUN_W-1:0] w_rate_nxt;
    logic               w_rate_term;
    logic               w_step_nxt;
    logic               w_latch_nxt;

    logic               r_step_pulse;
    logic               r_latch_pulse;
    logic               r_running;
    logic [31:0]        r_step_count;

    // Two-flop synchronizer for the asynchronous keys; released (1) after reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_s1 <= 3'b111;
            r_s2 <= 3'b111;
        end else begin
            r_s1 <= bus.key_n;
            r_s2 <= r_s1;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_key
        logic [c_DB_W-1:0] r_cnt;
        logic              r_db;
        logic              r_db_d;

        // Accept a level change only after it persists for DEBOUNCE_CYCLES;
        // any return to the stable level restarts qualification.
        always_ff @(posedge clock) begin
            if (!reset) begin
                r_cnt  <= '0;
                r_db   <= 1'b1;
                r_db_d <= 1'b1;
            end else begin
                r_db_d <= r_db;
                if (r_s2[gi] == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_TERM) begin
                    r_db  <= r_s2[gi];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_DB_ONE;
                end
            end
        end

        // Press is the falling edge of the debounced level; release is silent
        assign w_press[gi] = r_db_d & ~r_db;
    end

    assign w_rate_term = (r_rate == c_RUN_TERM);

    // Next-state logic: the run/stop toggle outranks both manual and auto steps
    always_comb begin
        w_state_nxt = r_state;
        w_rate_nxt  = r_rate;
        w_step_nxt  = 1'b0;
        w_latch_nxt = w_press[1];
        if (r_state == c_ST_RUN) begin
            if (w_press[2]) begin
                w_state_nxt = c_ST_IDLE;
                w_rate_nxt  = '0;
            end else if (w_rate_term) begin
                w_step_nxt  = 1'b1;
                w_rate_nxt  = '0;
            end else begin
                w_rate_nxt  = r_rate + c_RUN_ONE;
            end
        end else begin
            if (w_press[2]) begin
                w_state_nxt = c_ST_RUN;
                w_rate_nxt  = '0;
            end else if (w_press[0]) begin
                w_step_nxt  = 1'b1;
            end
        end
    end

    // State, rate counter and registered strobes
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= c_ST_IDLE;
            r_rate        <= '0;
            r_step_pulse  <= 1'b0;
            r_latch_pulse <= 1'b0;
            r_running     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rate        <= w_rate_nxt;
            r_step_pulse  <= w_step_nxt;
            r_latch_pulse <= w_latch_nxt;
            r_running     <= (w_state_nxt == c_ST_RUN);
        end
    end

    // Step counter trails step_pulse by one cycle and wraps naturally
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_step_count <= '0;
        end else if (r_step_pulse) begin
            r_step_count <= r_step_count + 32'd1;
        end
    end

    assign bus.step_pulse  = r_step_pulse;
    assign bus.latch_pulse = r_latch_pulse;
    assign bus.running     = r_running;
    assign bus.step_count  = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_controller
// Description : Directed self-checking bench for step_controller
//               (DEBOUNCE_CYCLES=4, RUN_DIVIDE=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_controller;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    step_controller_if bus ();

    step_controller #(
        .DEBOUNCE_CYCLES (4),
        .RUN_DIVIDE      (8)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge; the loop
    // index e is the number of the rising edge just completed.
    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.key_n = 3'b111;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst step_pulse",  {31'd0, bus.step_pulse},  32'd0);
        check("rst latch_pulse", {31'd0, bus.latch_pulse}, 32'd0);
        check("rst running",     {31'd0, bus.running},     32'd0);
        check("rst step_count",  bus.step_count,           32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- clean press: strobe at edge 6 ----------------
        for (int e = 0; e < 20; e++) begin
            bus.key_n[0] = (e <= 15) ? 1'b0 : 1'b1;
            @(negedge clk);
            check($sformatf("clean step e=%0d", e), {31'd0, bus.step_pulse}, {31'd0, e == 6});
            if (e == 7) check("clean count", bus.step_count, 32'd1);
        end
        repeat (8) @(negedge clk);
        check("clean count after release", bus.step_count, 32'd1);

        // ---------------- bounce: restart, strobe at edge 10 ----------------
        for (int e = 0; e < 18; e++) begin
            bus.key_n[0] = (e == 3 || e > 13) ? 1'b1 : 1'b0;
            @(negedge clk);
            check($sformatf("bounce step e=%0d", e), {31'd0, bus.step_pulse}, {31'd0, e == 10});
        end
        repeat (8) @(negedge clk);
        check("bounce count", bus.step_count, 32'd2);

        // -------- run/stop with simultaneous step, ignored manual step,
        // -------- latch in RUN, and stop on the terminal-count edge --------
        for (int e = 0; e < 61; e++) begin
            bus.key_n[0] = !((e < 10) || (e >= 20 && e < 30));
            bus.key_n[1] = !(e >= 20 && e < 30);
            bus.key_n[2] = !((e < 10) || (e >= 40 && e < 50));
            @(negedge clk);
            check($sformatf("run step e=%0d", e), {31'd0, bus.step_pulse},
                  {31'd0, (e == 14 || e == 22 || e == 30 || e == 38)});
            check($sformatf("run running e=%0d", e), {31'd0, bus.running},
                  {31'd0, (e >= 6 && e < 46)});
            check($sformatf("run latch e=%0d", e), {31'd0, bus.latch_pulse},
                  {31'd0, e == 26});
        end
        check("run count", bus.step_count, 32'd6);

        // ---------------- reset mid-run with rate counter at 5 ----------------
        for (int e = 0; e < 25; e++) begin
            bus.key_n[2] = (e < 8) ? 1'b0 : 1'b1;
            rst_n        = (e == 12) ? 1'b0 : 1'b1;
            @(negedge clk);
            check($sformatf("midrst step e=%0d", e), {31'd0, bus.step_pulse}, 32'd0);
            check($sformatf("midrst running e=%0d", e), {31'd0, bus.running},
                  {31'd0, (e >= 6 && e < 12)});
            if (e == 11) check("midrst count before", bus.step_count, 32'd6);
            if (e == 12) begin
                check("midrst latch",  {31'd0, bus.latch_pulse}, 32'd0);
                check("midrst count",  bus.step_count,           32'd0);
            end
        end
        rst_n = 1'b1;

        // ---------------- step_count wrap ----------------
        for (int e = 0; e < 10; e++) begin
            bus.key_n[0] = (e < 8) ? 1'b0 : 1'b1;
            @(negedge clk);
            check($sformatf("wrap step e=%0d", e), {31'd0, bus.step_pulse}, {31'd0, e == 6});
            if (e == 5) force dut.r_step_count = 32'hFFFF_FFFF;
            if (e == 6) begin
                check("wrap preload", bus.step_count, 32'hFFFF_FFFF);
                release dut.r_step_count;
            end
            if (e == 7) check("wrap count", bus.step_count, 32'h0000_0000);
        end
        bus.key_n = 3'b111;
        repeat (8) @(negedge clk);
        check("final count", bus.step_count, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/step_controller.md
# step_controller

Front-end pulse generator between the board pushbuttons and the processor core. It turns three raw, bouncing, active-low keys into clean single-cycle strobes on the free-running board clock:
- `step_pulse` advances the Mips core by one cycle.
- `latch_pulse` captures the register-out value for the hex displays.

It also provides an auto-run mode that issues steps at a fixed rate, and keeps a count of steps issued.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronized key must differ from its debounced state before the change is accepted (10 ms at 50 MHz); minimum 2
- RUN_DIVIDE, 5000000, cycles between automatic steps in RUN state; minimum 2

Ports:
- clock  in  1  board clock (50 MHz); all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- key_n  in  3  raw pushbuttons, active-low, asynchronous: [0] step, [1] latch, [2] run/stop toggle
- step_pulse  out  1  one-cycle strobe, advance core one cycle
- latch_pulse  out  1  one-cycle strobe, capture register-out value
- running  out  1  1 = RUN state (automatic stepping)
- step_count  out  32  number of step_pulse strobes since reset, modulo 2^32

## Operation
- Reset (reset=0 at an edge) sets the following:
  - Synchronizer flops and debounced states go to 1 (released).
  - Debounce counters and the rate counter go to 0.
  - State goes to IDLE.
  - step_pulse, latch_pulse, running and step_count all go to 0.
- Each key passes through a two-flop synchronizer (s1, s2).
- Each key has its own debouncer with counter cnt[i] and stable state db[i]:
  - s2==db: cnt cleared.
  - s2!=db and cnt<DEBOUNCE_CYCLES-1: cnt+1.
  - s2!=db and cnt==DEBOUNCE_CYCLES-1: db<=s2 and cnt cleared.
  - A bounce, i.e. s2 returning to db before terminal count, restarts the qualification from 0.
- Press event press[i] is high for exactly one cycle, the cycle after db[i] goes 1->0.
- Release, i.e. db going 0->1, produces no event.
- FSM states:
  - IDLE: press[0] -> step_pulse. press[2] -> RUN, and rate counter cleared.
  - RUN: rate counter counts 0..RUN_DIVIDE-1. At terminal count it produces step_pulse and wraps to 0. press[0] is ignored. press[2] -> IDLE, and rate counter cleared.
- press[1] -> latch_pulse in either state.
- Simultaneous events:
  - press[2] with press[0] in the same cycle: the toggle wins and the manual step is discarded.
  - press[2] in the same cycle as the RUN terminal count: the transition to IDLE wins and no step is issued.
  - press[1] is independent and is never discarded.
- step_count increments by 1 on every cycle step_pulse is high, and wraps 0xFFFFFFFF -> 0.
- A key held low through reset release is re-qualified from scratch. It produces one press event DEBOUNCE_CYCLES+2 edges after release.

## Timing
- All outputs are registered. Pulses are high for exactly one clock cycle and never on consecutive cycles from a single press.
- Edge 0 is the first edge sampling key_n[i]=0, with the key held stable afterward:
  - s2=0 after edge 1.
  - db=0 at edge DEBOUNCE_CYCLES+1.
  - press high during the following cycle.
  - The corresponding output (step_pulse, latch_pulse, or the running change) is registered at edge DEBOUNCE_CYCLES+2.
- Total press-to-strobe latency is DEBOUNCE_CYCLES+2 edges.
- Entering RUN: running rises at the toggle edge. The first automatic step_pulse follows RUN_DIVIDE edges later, then every RUN_DIVIDE edges.
- Leaving RUN: running falls at the toggle edge. No step_pulse occurs at or after that edge unless a new manual press arrives.
- step_count updates at the edge after step_pulse is high (it reflects the strobe one cycle later).
- Reset mid-operation takes effect at the next edge. Any in-flight qualification or rate count is discarded. No strobe is emitted in the cycle following a reset edge.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, RUN_DIVIDE=8.
- Clean press: key_n[0] driven low at edge 0 and held -> step_pulse high for one cycle after edge 6; step_count=1 after edge 7; no further pulse while held or on release.
- Bounce: key_n[0] low for 3 edges, high for 1, then low held -> qualification restarts; a single step_pulse, 6 edges after the final low is first sampled.
- Auto-run: press key_n[2] -> running=1; step_pulse at 8, 16, 24 edges after running rises. A second key_n[2] press -> running=0 and pulses stop. step_count equals the number of auto pulses.
- Conflicts:
  - In RUN, key_n[0] press -> no extra step_pulse.
  - key_n[2] and key_n[0] pressed on the same edge in IDLE -> running=1 and no step_pulse.
  - key_n[1] pressed in either state -> latch_pulse.
- Wrap: with step_count forced to 0xFFFFFFFF via a bench deposit, one step -> 0x00000000.
- Reset mid-run: reset=0 for one edge while running=1 with rate counter at 5 -> all outputs 0. No step_pulse for 8 edges after release unless keys are pressed.
